// File: rtl/aurora_tx_pkg.sv
// Shared constants and types for the Aurora 64b/66b TX lane.
// Block and SerDes word widths, sync headers, block type.
package aurora_tx_pkg;

    localparam int AURORA_BLOCK_W  = 66;
    localparam int AURORA_SERDES_W = 32;
    localparam int AURORA_FILL_W   = 7;

    localparam logic [1:0] AURORA_SYNC_DATA = 2'b01;
    localparam logic [1:0] AURORA_SYNC_CTRL = 2'b10;

    typedef logic [AURORA_BLOCK_W-1:0] aurora_block_t;

endpackage

// File: rtl/aurora_gb_insert_shift.sv
// Gearbox datapath: optional block insert at the fill offset,
// then split into the outgoing word and the remaining buffer.
module aurora_gb_insert_shift
    import aurora_tx_pkg::*;
#(
    parameter int IN_W  = AURORA_BLOCK_W,
    parameter int OUT_W = AURORA_SERDES_W,
    parameter int BUF_W = IN_W + OUT_W - 1
) (
    input  logic [BUF_W-1:0]         buf_q,
    input  logic [AURORA_FILL_W-1:0] fill,
    input  logic [IN_W-1:0]          data_in,
    input  logic                     load,
    output logic [BUF_W-1:0]         buf_next,
    output logic [OUT_W-1:0]         word
);

    logic [BUF_W-1:0] keep_mask;
    logic [BUF_W-1:0] ins;
    logic [BUF_W-1:0] t;

    // Bits above the fill level are cleared before the OR so no stale data leaks in.
    always_comb begin
        keep_mask = ~({BUF_W{1'b1}} << fill);
        ins       = {{(BUF_W-IN_W){1'b0}}, data_in} << fill;
        t         = load ? ((buf_q & keep_mask) | ins) : buf_q;
        buf_next  = t >> OUT_W;
        word      = t[OUT_W-1:0];
    end

endmodule

// File: rtl/aurora_tx_gearbox_66to32.sv
// TX gearbox: packs 66-bit scrambled blocks into gapless 32-bit words.
// BlockReq is the combinational advance enable for the scrambler.
module aurora_tx_gearbox_66to32
    import aurora_tx_pkg::*;
#(
    parameter int IN_W  = AURORA_BLOCK_W,
    parameter int OUT_W = AURORA_SERDES_W
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     OutEna,
    input  logic [IN_W-1:0]          DataIn,
    output logic                     BlockReq,
    output logic [OUT_W-1:0]         DataOut,
    output logic                     DataOutValid,
    output logic [AURORA_FILL_W-1:0] FillLevel
);

    localparam int BUF_W = IN_W + OUT_W - 1;

    localparam logic [AURORA_FILL_W-1:0] FILL_INC = AURORA_FILL_W'(IN_W - OUT_W);
    localparam logic [AURORA_FILL_W-1:0] FILL_DEC = AURORA_FILL_W'(OUT_W);

    logic [BUF_W-1:0]         buf_q;
    logic [BUF_W-1:0]         buf_next;
    logic [OUT_W-1:0]         word;
    logic [AURORA_FILL_W-1:0] fill_q;
    logic                     need_block;

    assign need_block = fill_q < FILL_DEC;
    assign BlockReq   = OutEna && need_block && !Rst;

    aurora_gb_insert_shift #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .BUF_W (BUF_W)
    ) u_insert_shift (
        .buf_q    (buf_q),
        .fill     (fill_q),
        .data_in  (DataIn),
        .load     (BlockReq),
        .buf_next (buf_next),
        .word     (word)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            buf_q        <= '0;
            fill_q       <= '0;
            DataOut      <= '0;
            DataOutValid <= 1'b0;
        end else if (OutEna) begin
            buf_q        <= buf_next;
            DataOut      <= word;
            DataOutValid <= 1'b1;
            fill_q       <= need_block ? fill_q + FILL_INC : fill_q - FILL_DEC;
        end else begin
            DataOutValid <= 1'b0;
        end
    end

    assign FillLevel = fill_q;

endmodule
